// File: rtl/cgra_config_pkg.sv
// Shared types and CRC constants for the CGRA config loader.
// The optional CRC check is enabled by defining CONFIG_LOADER_CRC_EN.
package cgra_config_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        CHECK,
        ACTIVE,
        ERROR
    } loader_state_t;

    localparam int             CFG_CRC_W    = 8;
    localparam logic [7:0]     CFG_CRC_POLY = 8'h07;
    localparam logic [7:0]     CFG_CRC_INIT = 8'h00;

endpackage

// File: rtl/cgra_config_crc8.sv
// Serial MSB-first CRC-8 LFSR. Clear and enable in the same cycle folds
// the incoming bit into a freshly initialised register.
module cgra_config_crc8
    import cgra_config_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic                 enable,
    input  logic                 bit_in,
    output logic [CFG_CRC_W-1:0] crc
);

    logic [CFG_CRC_W-1:0] base;
    logic                 fb;
    logic [CFG_CRC_W-1:0] crc_next;

    always_comb begin
        base     = clear ? CFG_CRC_INIT : crc;
        fb       = base[CFG_CRC_W-1] ^ bit_in;
        crc_next = {base[CFG_CRC_W-2:0], 1'b0} ^ (fb ? CFG_CRC_POLY : '0);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            crc <= CFG_CRC_INIT;
        end else if (enable) begin
            crc <= crc_next;
        end else if (clear) begin
            crc <= CFG_CRC_INIT;
        end
    end

endmodule

// File: rtl/cgra_config_loader.sv
// Serial-to-parallel config sink: shifts the configurator stream, checks its
// length (and CRC-8 when CONFIG_LOADER_CRC_EN is defined), then commits it.
module cgra_config_loader
    import cgra_config_pkg::*;
#(
    parameter int NUM_BITS = 465,
    parameter int CNT_W    = 10
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                bitstream,
    input  logic                bit_valid,
    input  logic                cfg_done,
    output logic [NUM_BITS-1:0] config_out,
    output logic                config_valid,
    output logic                load_error,
    output logic [CNT_W-1:0]    bit_count
);

`ifdef CONFIG_LOADER_CRC_EN
    localparam int EXPECTED = NUM_BITS + CFG_CRC_W;
`else
    localparam int EXPECTED = NUM_BITS;
`endif
    localparam logic [CNT_W-1:0] EXP_CNT = CNT_W'(EXPECTED);

    loader_state_t       state;
    logic [NUM_BITS-1:0] shift_reg;
    logic                start;
    logic                accept;
    logic                shift_en;
    logic                crc_ok;

    // A bit arriving outside SHIFT/CHECK begins a fresh load
    assign start  = bit_valid && (state == IDLE || state == ACTIVE || state == ERROR);
    assign accept = bit_valid && (start || state == SHIFT);

`ifdef CONFIG_LOADER_CRC_EN
    localparam logic [CNT_W-1:0] PAY_CNT = CNT_W'(NUM_BITS);

    logic                 payload_bit;
    logic [CFG_CRC_W-1:0] crc_calc;
    logic [CFG_CRC_W-1:0] crc_rx;

    // Count before increment is the index of the bit now arriving
    assign payload_bit = start || (bit_count < PAY_CNT);
    assign shift_en    = accept && payload_bit;
    assign crc_ok      = (crc_rx == crc_calc);

    cgra_config_crc8 u_crc (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (start),
        .enable  (shift_en),
        .bit_in  (bitstream),
        .crc     (crc_calc)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            crc_rx <= '0;
        end else if (accept && !payload_bit) begin
            crc_rx <= {crc_rx[CFG_CRC_W-2:0], bitstream};
        end
    end
`else
    assign shift_en = accept;
    assign crc_ok   = 1'b1;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            shift_reg    <= '0;
            config_out   <= '0;
            config_valid <= 1'b0;
            load_error   <= 1'b0;
            bit_count    <= '0;
        end else begin
            if (shift_en) begin
                shift_reg <= {shift_reg[NUM_BITS-2:0], bitstream};
            end
            if (start) begin
                bit_count <= CNT_W'(1);
            end else if (accept && bit_count != '1) begin
                bit_count <= bit_count + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (bit_valid) state <= SHIFT;
                end
                SHIFT: begin
                    if (cfg_done) state <= CHECK;
                end
                CHECK: begin
                    if (bit_count == EXP_CNT && crc_ok) begin
                        config_out   <= shift_reg;
                        config_valid <= 1'b1;
                        state        <= ACTIVE;
                    end else begin
                        load_error <= 1'b1;
                        state      <= ERROR;
                    end
                end
                ACTIVE, ERROR: begin
                    // Old image stays on config_out until the reload commits
                    if (bit_valid) begin
                        config_valid <= 1'b0;
                        load_error   <= 1'b0;
                        state        <= SHIFT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cgra_config_loader.sv
// Directed bench for cgra_config_loader at NUM_BITS=16, CNT_W=6.
// Build with CONFIG_LOADER_CRC_EN defined to also exercise the CRC path.
module tb_cgra_config_loader;

    localparam int NUM_BITS = 16;
    localparam int CNT_W    = 6;
`ifdef CONFIG_LOADER_CRC_EN
    localparam logic [CNT_W-1:0] EXP = 6'd24;
`else
    localparam logic [CNT_W-1:0] EXP = 6'd16;
`endif
    // CRC-8/0x07/init 0 of the payload words, worked out by hand
    localparam logic [7:0] CRC_A5C3 = 8'h1E;
    localparam logic [7:0] CRC_1234 = 8'hF1;

    logic                clock = 1'b0;
    logic                reset_n = 1'b0;
    logic                bitstream = 1'b0;
    logic                bit_valid = 1'b0;
    logic                cfg_done = 1'b0;
    logic [NUM_BITS-1:0] config_out;
    logic                config_valid;
    logic                load_error;
    logic [CNT_W-1:0]    bit_count;

    int vectors = 0;
    int miscompares = 0;

    cgra_config_loader #(.NUM_BITS(NUM_BITS), .CNT_W(CNT_W)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .bitstream    (bitstream),
        .bit_valid    (bit_valid),
        .cfg_done     (cfg_done),
        .config_out   (config_out),
        .config_valid (config_valid),
        .load_error   (load_error),
        .bit_count    (bit_count)
    );

    always #5 clock = ~clock;

    task automatic send_bits(input logic [31:0] data, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge clock);
            bit_valid = 1'b1;
            bitstream = data[i];
        end
    endtask

    task automatic send_image(input logic [15:0] d, input logic [7:0] crc);
        send_bits({16'h0, d}, 16);
`ifdef CONFIG_LOADER_CRC_EN
        send_bits({24'h0, crc}, 8);
`else
        if (crc == 8'hxx) $display("unreachable");
`endif
    endtask

    // Returns at the negedge two cycles after cfg_done was raised
    task automatic finish_load();
        @(negedge clock);
        bit_valid = 1'b0;
        cfg_done  = 1'b1;
        @(negedge clock);
        cfg_done  = 1'b0;
        vectors++;
        if (config_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL latency_early: config_valid=%b required 0", config_valid);
        end
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        bit_valid = 1'b0;
        cfg_done  = 1'b0;
        bitstream = 1'b0;
        repeat (2) @(negedge clock);
        vectors++;
        if ({config_out, config_valid, load_error, bit_count} !== '0) begin
            miscompares++;
            $display("FAIL reset: out=%h valid=%b err=%b cnt=%0d required all 0",
                     config_out, config_valid, load_error, bit_count);
        end
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_good_load();
        send_image(16'hA5C3, CRC_A5C3);
        finish_load();
        vectors++;
        if (config_out !== 16'hA5C3 || config_valid !== 1'b1 || load_error !== 1'b0 || bit_count !== EXP) begin
            miscompares++;
            $display("FAIL good_load: out=%h valid=%b err=%b cnt=%0d required a5c3 1 0 %0d",
                     config_out, config_valid, load_error, bit_count, EXP);
        end
    endtask

    task automatic test_done_ignored();
        cfg_done = 1'b1;
        repeat (3) @(negedge clock);
        vectors++;
        if (config_out !== 16'hA5C3 || config_valid !== 1'b1 || load_error !== 1'b0 || bit_count !== EXP) begin
            miscompares++;
            $display("FAIL done_ignored: out=%h valid=%b err=%b cnt=%0d required a5c3 1 0 %0d",
                     config_out, config_valid, load_error, bit_count, EXP);
        end
        cfg_done = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reload();
        @(negedge clock);
        bit_valid = 1'b1;
        bitstream = 1'b0;
        @(negedge clock);
        vectors++;
        if (config_valid !== 1'b0 || config_out !== 16'hA5C3 || bit_count !== 6'd1) begin
            miscompares++;
            $display("FAIL reload_start: valid=%b out=%h cnt=%0d required 0 a5c3 1",
                     config_valid, config_out, bit_count);
        end
        bit_valid = 1'b0;
        send_bits(32'h1234, 15);
`ifdef CONFIG_LOADER_CRC_EN
        send_bits({24'h0, CRC_1234}, 8);
`endif
        @(negedge clock);
        bit_valid = 1'b0;
        vectors++;
        if (config_out !== 16'hA5C3 || config_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reload_hold: out=%h valid=%b required a5c3 0", config_out, config_valid);
        end
        cfg_done = 1'b1;
        @(negedge clock);
        cfg_done = 1'b0;
        @(negedge clock);
        vectors++;
        if (config_out !== 16'h1234 || config_valid !== 1'b1 || load_error !== 1'b0) begin
            miscompares++;
            $display("FAIL reload_commit: out=%h valid=%b err=%b required 1234 1 0",
                     config_out, config_valid, load_error);
        end
    endtask

    task automatic test_overflow();
        send_bits(32'h1_A5C3, 17);
        finish_load();
        vectors++;
        if (load_error !== 1'b1 || config_valid !== 1'b0 || config_out !== 16'h1234 || bit_count !== 6'd17) begin
            miscompares++;
            $display("FAIL overflow: err=%b valid=%b out=%h cnt=%0d required 1 0 1234 17",
                     load_error, config_valid, config_out, bit_count);
        end
    endtask

    task automatic test_short();
        send_bits(32'h52E1, 15);
        finish_load();
        vectors++;
        if (load_error !== 1'b1 || config_valid !== 1'b0 || config_out !== 16'h0000 || bit_count !== 6'd15) begin
            miscompares++;
            $display("FAIL short: err=%b valid=%b out=%h cnt=%0d required 1 0 0000 15",
                     load_error, config_valid, config_out, bit_count);
        end
    endtask

    task automatic test_mid_reset();
        send_image(16'hA5C3, CRC_A5C3);
        finish_load();
        send_bits(32'h12, 8);
        @(negedge clock);
        bit_valid = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        vectors++;
        if ({config_out, config_valid, load_error, bit_count} !== '0) begin
            miscompares++;
            $display("FAIL mid_reset: out=%h valid=%b err=%b cnt=%0d required all 0",
                     config_out, config_valid, load_error, bit_count);
        end
        @(negedge clock);
        reset_n = 1'b1;
        send_image(16'h1234, CRC_1234);
        finish_load();
        vectors++;
        if (config_out !== 16'h1234 || config_valid !== 1'b1 || load_error !== 1'b0 || bit_count !== EXP) begin
            miscompares++;
            $display("FAIL after_reset_load: out=%h valid=%b err=%b cnt=%0d required 1234 1 0 %0d",
                     config_out, config_valid, load_error, bit_count, EXP);
        end
    endtask

`ifdef CONFIG_LOADER_CRC_EN
    task automatic test_crc();
        send_image(16'hA5C3, CRC_A5C3);
        finish_load();
        vectors++;
        if (config_out !== 16'hA5C3 || config_valid !== 1'b1 || load_error !== 1'b0) begin
            miscompares++;
            $display("FAIL crc_good: out=%h valid=%b err=%b required a5c3 1 0",
                     config_out, config_valid, load_error);
        end
        send_image(16'h1234, CRC_1234 ^ 8'h01);
        finish_load();
        vectors++;
        if (config_out !== 16'hA5C3 || config_valid !== 1'b0 || load_error !== 1'b1 || bit_count !== EXP) begin
            miscompares++;
            $display("FAIL crc_bad: out=%h valid=%b err=%b cnt=%0d required a5c3 0 1 %0d",
                     config_out, config_valid, load_error, bit_count, EXP);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_good_load();
        test_done_ignored();
        test_reload();
        test_overflow();
        test_reset();
        test_short();
        test_reset();
        test_mid_reset();
`ifdef CONFIG_LOADER_CRC_EN
        test_reset();
        test_crc();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
